// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: arms an external board_timer for gap/visible windows and scores hits.
// Optional MOLE_SCHED_NO_REPEAT_EN: never light the same hole in two consecutive rounds of a game.
module mole_scheduler #(
  parameter logic [27:0] GAP_TICKS  = 28'd50_000_000,
  parameter logic [27:0] UP_TICKS   = 28'd100_000_000,
  parameter int unsigned NUM_ROUNDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  level,
  input  logic [3:0]  btn,
  input  logic        time_trigger,
  output logic        timer_load,
  output logic [27:0] timer_loadval,
  output logic [3:0]  mole,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [7:0]  score,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TW = 28;
  localparam int unsigned RW = 6;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM_GAP, S_GAP, S_ARM_UP, S_UP, S_RESULT, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [RW-1:0]   round_q, round_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      idx_q, idx_d;
  logic            timer_load_q, timer_load_d;
  logic [TW-1:0]   timer_loadval_q, timer_loadval_d;
  logic [3:0]      mole_q, mole_d;
  logic            hit_q, miss_q;
  logic [7:0]      score_q, score_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hit_c, miss_c, start_ok_c;
  logic [1:0]      next_idx_c;

  assign hit_c      = (state_q == S_UP) && btn[idx_q];
  assign miss_c     = (state_q == S_UP) && !hit_c && time_trigger;
  assign start_ok_c = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign lfsr_d     = {lfsr_q[6:0], ^(lfsr_q & 8'hB8)};

`ifdef MOLE_SCHED_NO_REPEAT_EN
  assign next_idx_c = (lfsr_q[1:0] == idx_q) ? 2'(lfsr_q[1:0] + 2'd1) : lfsr_q[1:0];
`else
  assign next_idx_c = lfsr_q[1:0];
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_SEED;
      round_q         <= '0;
      level_q         <= '0;
      idx_q           <= '0;
      timer_load_q    <= 1'b0;
      timer_loadval_q <= '0;
      mole_q          <= '0;
      hit_q           <= 1'b0;
      miss_q          <= 1'b0;
      score_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      round_q         <= round_d;
      level_q         <= level_d;
      idx_q           <= idx_d;
      timer_load_q    <= timer_load_d;
      timer_loadval_q <= timer_loadval_d;
      mole_q          <= mole_d;
      hit_q           <= hit_c;
      miss_q          <= miss_c;
      score_q         <= score_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // Next-state logic; time_trigger is only looked at in GAP and UP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_ARM_GAP;
      S_ARM_GAP:      state_d = S_GAP;
      S_GAP:          if (time_trigger) state_d = S_ARM_UP;
      S_ARM_UP:       state_d = S_UP;
      S_UP:           if (hit_c || time_trigger) state_d = S_RESULT;
      S_RESULT:       state_d = (round_q == RW'(NUM_ROUNDS)) ? S_DONE : S_ARM_GAP;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, computed from the upcoming state
  always_comb begin
    timer_load_d    = 1'b0;
    timer_loadval_d = '0;
    mole_d          = mole_q;
    score_d         = score_q;
    round_d         = round_q;
    level_d         = level_q;
    idx_d           = idx_q;
    busy_d          = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d          = (state_d == S_DONE);

    if (start_ok_c) begin
      level_d = level;
      score_d = '0;
      round_d = '0;
      idx_d   = '0;
    end
    if (state_d == S_ARM_GAP) begin
      timer_load_d    = 1'b1;
      timer_loadval_d = GAP_TICKS;
    end
    if (state_d == S_ARM_UP) begin
      timer_load_d    = 1'b1;
      timer_loadval_d = UP_TICKS >> level_q;
    end
    if (state_q == S_ARM_UP) begin
      idx_d  = next_idx_c;
      mole_d = 4'(4'b0001 << next_idx_c);
    end
    if (hit_c || miss_c) begin
      mole_d  = '0;
      round_d = RW'(round_q + RW'(1));
    end
    if (hit_c && (score_q != 8'hFF)) score_d = 8'(score_q + 8'd1);
  end

  assign timer_load    = timer_load_q;
  assign timer_loadval = timer_loadval_q;
  assign mole          = mole_q;
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;
  assign score         = score_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: timed scoreboard of load/hit/miss strobes against a cycle-schedule model.
module tb_mole_scheduler;

  localparam int G  = 4;
  localparam int U  = 8;
  localparam int NR = 3;
`ifdef MOLE_SCHED_NO_REPEAT_EN
  localparam int NGAMES = 70;
`else
  localparam int NGAMES = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  level;
  logic [3:0]  btn;
  logic        time_trigger;
  logic        timer_load;
  logic [27:0] timer_loadval;
  logic [3:0]  mole;
  logic        hit_pulse, miss_pulse;
  logic [7:0]  score;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  logic [27:0] tcnt = '0;

  typedef struct {
    int          at;
    int          kind;   // 0 load, 1 hit, 2 miss
    logic [27:0] val;
    int          sc;
  } ev_t;
  ev_t q[$];

  mole_scheduler #(.GAP_TICKS(28'd4), .UP_TICKS(28'd8), .NUM_ROUNDS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .level(level), .btn(btn),
    .time_trigger(time_trigger), .timer_load(timer_load), .timer_loadval(timer_loadval),
    .mole(mole), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // board_timer stand-in
  always @(posedge clk) begin
    if (timer_load) tcnt <= timer_loadval;
    else if (tcnt != 0) tcnt <= tcnt - 28'd1;
  end
  assign time_trigger = (tcnt == 0);

  // cycles since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int k);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every strobe must match the next scheduled event
  always @(negedge clk) begin : mon
    int   nst;
    int   kind;
    ev_t  e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missing_event kind %0d due cycle %0d, now %0d", e.kind, e.at, cyc);
      end
      nst = int'(timer_load) + int'(hit_pulse) + int'(miss_pulse);
      if (nst != 0) begin
        chk("one_strobe", nst, 1);
        kind = hit_pulse ? 1 : (miss_pulse ? 2 : 0);
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe kind %0d at cycle %0d", kind, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_cycle", cyc, e.at);
          chk("ev_kind", kind, e.kind);
          chk("ev_score", int'(score), e.sc);
          if (kind == 0) chk("loadval", int'(timer_loadval), int'(e.val));
          else chk("mole_cleared", int'(mole), 0);
        end
      end else begin
        chk("loadval_idle", int'(timer_loadval), 0);
      end
    end
  end

  task automatic play_game(input logic [1:0] lvl, input bit busy_start);
    int t, up, v, res, hc, sc, act;
    logic [1:0] prev, idx, w;
    logic [3:0] prev_mole;
    @(negedge clk);
    t = cyc + 1; v = U >> lvl; sc = 0; prev = 2'd0; res = t; prev_mole = 4'd0;
    start = 1'b1; level = lvl;
    @(negedge clk);
    start = 1'b0; level = 2'($urandom);
    for (int r = 0; r < NR; r++) begin
      up  = t + G + 2;
      idx = lfsr_at(up) & 8'h03;
`ifdef MOLE_SCHED_NO_REPEAT_EN
      if (idx == prev) idx = idx + 2'd1;
`endif
      act = $urandom_range(0, 3);
      q.push_back('{t, 0, 28'(G), sc});
      q.push_back('{up, 0, 28'(v), sc});
      if (act == 1 || act == 2) begin
        hc  = (act == 2) ? up + 1 + v : up + 1 + $urandom_range(0, v - 1);
        res = hc + 1;
        if (sc < 255) sc++;
        q.push_back('{res, 1, 28'd0, sc});
      end else begin
        res = up + 2 + v;
        q.push_back('{res, 2, 28'd0, sc});
      end
      wait_cyc(t + 2);
      btn = 4'hF;
      @(negedge clk);
      btn = 4'h0;
      if (busy_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(up + 1);
      chk("mole_lit", int'(mole), int'(4'b0001 << idx));
      chk("busy_up", int'(busy), 1);
      chk("done_up", int'(done), 0);
`ifdef MOLE_SCHED_NO_REPEAT_EN
      if (r > 0) chk("no_repeat", int'(mole != prev_mole), 1);
`endif
      prev_mole = mole;
      if (act == 1 || act == 2) begin
        wait_cyc(hc);
        btn = 4'(4'b0001 << idx);
        @(negedge clk);
        btn = 4'h0;
      end else if (act == 3) begin
        wait_cyc(up + 1 + $urandom_range(0, v - 1));
        w = idx + 2'($urandom_range(1, 3));
        btn = 4'(4'b0001 << w);
        @(negedge clk);
        btn = 4'h0;
      end
      prev = idx;
      t = res + 1;
    end
    wait_cyc(res + 1);
    chk("done_end", int'(done), 1);
    chk("busy_end", int'(busy), 0);
    chk("score_end", int'(score), sc);
    chk("mole_end", int'(mole), 0);
  endtask

  task automatic abort_game(input logic [1:0] lvl);
    int t, up;
    @(negedge clk);
    t = cyc + 1; up = t + G + 2;
    q.push_back('{t, 0, 28'(G), 0});
    q.push_back('{up, 0, 28'(U >> lvl), 0});
    start = 1'b1; level = lvl;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(up + 2);
    chk("mole_before_rst", int'(mole != 4'd0), 1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_mole", int'(mole), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_load", int'(timer_load), 0);
    chk("rst_score", int'(score), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; level = 2'd0; btn = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_mole", int'(mole), 0);
    chk("reset_load", int'(timer_load), 0);
    chk("reset_loadval", int'(timer_loadval), 0);
    chk("reset_hit", int'(hit_pulse), 0);
    chk("reset_miss", int'(miss_pulse), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    play_game(2'd0, 1'b1);
    play_game(2'd3, 1'b0);
    abort_game(2'd1);
    play_game(2'd0, 1'b0);
    for (int g = 0; g < NGAMES; g++) play_game(2'($urandom), 1'($urandom));
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
